// File: rtl/fft_top_prod_requant.sv
// Requantizer for FFT butterfly products: round-half-even right shift, saturate,
// count overflows. Two-stage pipeline, shift amount frozen per frame.
module fft_top_prod_requant #(
    parameter int DIN_WIDTH  = 37,
    parameter int DOUT_WIDTH = 22,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         ce,
    input  logic signed [DIN_WIDTH-1:0]  din,
    input  logic                         din_valid,
    input  logic                         din_last,
    input  logic [3:0]                   shift_cfg,
    input  logic                         ovf_clr,
    output logic signed [DOUT_WIDTH-1:0] dout,
    output logic                         dout_valid,
    output logic                         dout_last,
    output logic                         ovf,
    output logic [CNT_WIDTH-1:0]         ovf_count
);
    // One guard bit above the input keeps the rounding increment from wrapping.
    localparam int EW     = DIN_WIDTH + 1;
    localparam int STAGES = 2;
    localparam logic [EW-1:0]        ONE     = {{(EW-1){1'b0}}, 1'b1};
    localparam logic signed [EW-1:0] SAT_MAX = {{(EW-DOUT_WIDTH+1){1'b0}}, {(DOUT_WIDTH-1){1'b1}}};
    localparam logic signed [EW-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic {IDLE = 1'b0, IN_FRAME = 1'b1} state_t;

    typedef struct packed {
        logic signed [EW-1:0] val;
        logic                 last;
    } stage_t;

    state_t      state;
    logic [3:0]  shift_act;
    logic [3:0]  shift_eff;
    logic        frame_start;

    // The first beat of a frame already uses the incoming shift_cfg.
    assign frame_start = (state == IDLE) && din_valid;
    assign shift_eff   = frame_start ? shift_cfg : shift_act;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            shift_act <= 4'd0;
        end else if (ce) begin
            if (frame_start)
                shift_act <= shift_cfg;
            case (state)
                IDLE:     if (din_valid && !din_last) state <= IN_FRAME;
                IN_FRAME: if (din_valid && din_last)  state <= IDLE;
                default:  state <= IDLE;
            endcase
        end
    end

    logic signed [EW-1:0] din_ext;
    logic signed [EW-1:0] q;
    logic signed [EW-1:0] rnd;
    logic [EW-1:0]        pow_s;
    logic [EW-1:0]        mask;
    logic [EW-1:0]        half;
    logic [EW-1:0]        rem;
    logic                 round_up;

    assign din_ext  = {din[DIN_WIDTH-1], din};
    assign q        = din_ext >>> shift_eff;
    assign pow_s    = ONE << shift_eff;
    assign mask     = pow_s - ONE;
    assign half     = pow_s >> 1;
    assign rem      = $unsigned(din_ext) & mask;
    // Ties go to the even neighbour; a zero shift never rounds.
    assign round_up = (shift_eff != 4'd0) && ((rem > half) || ((rem == half) && q[0]));
    assign rnd      = q + $signed({{(EW-1){1'b0}}, round_up});

    logic [STAGES:1] vld_pipe;
    stage_t          s1;

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_pipe <= '0;
            s1       <= '0;
        end else if (ce) begin
            vld_pipe <= {vld_pipe[STAGES-1:1], din_valid};
            s1       <= '{val: rnd, last: din_last};
        end
    end

    assign dout_valid = vld_pipe[STAGES];

    logic                         sat_hi;
    logic                         sat_lo;
    logic                         ovf_next;
    logic signed [DOUT_WIDTH-1:0] dout_next;

    assign sat_hi   = $signed(s1.val) > SAT_MAX;
    assign sat_lo   = $signed(s1.val) < SAT_MIN;
    assign ovf_next = vld_pipe[1] && (sat_hi || sat_lo);

    always_comb begin
        dout_next = s1.val[DOUT_WIDTH-1:0];
        if (sat_hi)
            dout_next = SAT_MAX[DOUT_WIDTH-1:0];
        else if (sat_lo)
            dout_next = SAT_MIN[DOUT_WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dout      <= '0;
            dout_last <= 1'b0;
            ovf       <= 1'b0;
        end else if (ce) begin
            dout      <= dout_next;
            dout_last <= s1.last;
            ovf       <= ovf_next;
        end
    end

    // Counted as the saturated beat is issued; clear wins over that increment.
    always_ff @(posedge clk) begin
        if (reset)
            ovf_count <= '0;
        else if (ovf_clr)
            ovf_count <= '0;
        else if (ce && ovf_next && (ovf_count != '1))
            ovf_count <= ovf_count + 1'b1;
    end

endmodule

// File: tb/tb_fft_top_prod_requant.sv
// Bench for fft_top_prod_requant: directed scenarios plus random traffic,
// every cycle compared against an arithmetic frame/pipeline reference.
module tb_fft_top_prod_requant;
    localparam int DW = 37;
    localparam int OW = 22;
    localparam int CW = 16;
    localparam longint OMAX = (longint'(1) << (OW-1)) - 1;
    localparam longint OMIN = -(longint'(1) << (OW-1));
    localparam longint CMAX = (longint'(1) << CW) - 1;

    logic                 clk = 1'b0;
    logic                 reset, ce, din_valid, din_last, ovf_clr;
    logic signed [DW-1:0] din;
    logic [3:0]           shift_cfg;
    logic signed [OW-1:0] dout;
    logic                 dout_valid, dout_last, ovf;
    logic [CW-1:0]        ovf_count;

    int n_chk = 0;
    int n_err = 0;

    fft_top_prod_requant #(.DIN_WIDTH(DW), .DOUT_WIDTH(OW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset), .ce(ce), .din(din), .din_valid(din_valid),
        .din_last(din_last), .shift_cfg(shift_cfg), .ovf_clr(ovf_clr),
        .dout(dout), .dout_valid(dout_valid), .dout_last(dout_last),
        .ovf(ovf), .ovf_count(ovf_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit     vld;
        bit     last;
        bit     ovf;
        longint val;
    } beat_t;

    beat_t  m_s1, m_out;
    bit     m_frame;
    int     m_shift;
    longint m_cnt;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Floor division by 2^s, round half to even, then clamp to the output range.
    function automatic void ref_rq(input longint d, input int s, output longint y, output bit o);
        longint p, q, r;
        p = longint'(1) << s;
        q = d / p;
        if ((d % p != 0) && (d < 0)) q = q - 1;
        r = d - q * p;
        if (s > 0 && ((r > p / 2) || (r == p / 2 && (q % 2 != 0)))) q = q + 1;
        o = (q > OMAX) || (q < OMIN);
        y = (q > OMAX) ? OMAX : (q < OMIN) ? OMIN : q;
    endfunction

    task automatic model_step();
        bit    inc;
        beat_t nb;
        int    s;
        inc = 1'b0;
        if (reset) begin
            m_s1    = '{0, 0, 0, 0};
            m_out   = '{0, 0, 0, 0};
            m_frame = 1'b0;
            m_shift = 0;
            m_cnt   = 0;
        end else begin
            if (ce) begin
                s = (!m_frame && din_valid) ? int'(shift_cfg) : m_shift;
                if (!m_frame && din_valid) m_shift = int'(shift_cfg);
                nb.vld  = din_valid;
                nb.last = din_last;
                ref_rq(longint'(din), s, nb.val, nb.ovf);
                m_out     = m_s1;
                m_out.ovf = m_s1.vld && m_s1.ovf;
                inc       = m_out.ovf;
                m_s1      = nb;
                if (din_valid) m_frame = !din_last;
            end
            if (ovf_clr) m_cnt = 0;
            else if (inc && m_cnt < CMAX) m_cnt = m_cnt + 1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("valid", dout_valid, m_out.vld);
        chk("ovf_count", ovf_count, m_cnt);
        if (m_out.vld) begin
            chk("dout", dout, m_out.val);
            chk("dout_last", dout_last, m_out.last);
            chk("ovf", ovf, m_out.ovf);
        end else begin
            chk("ovf_idle", ovf, 0);
        end
    endtask

    task automatic beat(input longint d, input bit last);
        din_valid = 1'b1;
        din_last  = last;
        din       = DW'(d);
        tick();
        din_valid = 1'b0;
        din_last  = 1'b0;
    endtask

    initial begin
        int     n_out, last_at, s;
        longint d, k;
        logic signed [DW-1:0] v;

        reset = 1'b1; ce = 1'b1; din_valid = 1'b0; din_last = 1'b0;
        ovf_clr = 1'b0; din = '0; shift_cfg = 4'd0;
        repeat (3) tick();
        chk("rst_dout", dout, 0);
        chk("rst_valid", dout_valid, 0);
        chk("rst_last", dout_last, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_cnt", ovf_count, 0);
        reset = 1'b0;

        // Ties at shift 15, positive side
        shift_cfg = 4'd15;
        beat(3 * 32768 + 16384, 0);
        chk("lat_early", dout_valid, 0);
        beat(2 * 32768 + 16384, 1);
        chk("tie_odd_up", dout, 4);
        tick();
        chk("tie_even_hold", dout, 2);

        // Ties at shift 15, negative side
        beat(-16384, 0);
        beat(-49152, 1);
        chk("neg_tie_a", dout, 0);
        chk("neg_tie_a_ovf", ovf, 0);
        tick();
        chk("neg_tie_b", dout, -2);
        chk("neg_tie_b_ovf", ovf, 0);

        // Saturation at both rails
        shift_cfg = 4'd0;
        beat((longint'(1) << 36) - 1, 0);
        beat(-(longint'(1) << 36), 1);
        chk("sat_hi", dout, 2097151);
        chk("sat_hi_ovf", ovf, 1);
        tick();
        chk("sat_lo", dout, -2097152);
        chk("sat_lo_ovf", ovf, 1);
        chk("sat_cnt", ovf_count, 2);

        // Shift change mid-frame only affects the next frame
        shift_cfg = 4'd4;
        beat(256, 0);
        shift_cfg = 4'd8;
        beat(256, 0);
        beat(256, 0);
        beat(256, 1);
        chk("frame_shift_b2", dout, 16);
        beat(256, 1);
        chk("frame_shift_b3", dout, 16);
        chk("frame_shift_last", dout_last, 1);
        tick();
        chk("next_frame_shift", dout, 1);

        // Clock enable toggling every cycle through a 4-beat frame
        shift_cfg = 4'd2;
        n_out = 0; last_at = 0;
        for (int i = 0; i < 7; i++) begin
            din_valid = (i < 4);
            din_last  = (i == 3);
            din       = DW'(longint'($urandom_range(0, 4095)) - 2048);
            ce = 1'b1;
            tick();
            if (dout_valid) begin
                n_out++;
                if (dout_last) last_at = n_out;
            end
            ce = 1'b0;
            tick();
        end
        ce = 1'b1; din_valid = 1'b0; din_last = 1'b0;
        chk("ce_nout", n_out, 4);
        chk("ce_last_at", last_at, 4);

        // Drive the overflow counter into saturation
        shift_cfg = 4'd0;
        for (int i = 0; i < 65540; i++) beat((longint'(1) << 36) - 1, 1);
        chk("cnt_sat", ovf_count, 65535);
        ce = 1'b0; ovf_clr = 1'b1;
        tick();
        chk("clr_ovf_held", ovf, 1);
        chk("clr_cnt", ovf_count, 0);
        ovf_clr = 1'b0; ce = 1'b1;

        // Reset in the middle of a frame
        shift_cfg = 4'd4;
        beat(256, 0);
        beat(256, 0);
        reset = 1'b1; din_valid = 1'b1; din_last = 1'b0;
        tick();
        chk("mid_rst_dout", dout, 0);
        chk("mid_rst_valid", dout_valid, 0);
        chk("mid_rst_last", dout_last, 0);
        chk("mid_rst_ovf", ovf, 0);
        chk("mid_rst_cnt", ovf_count, 0);
        reset = 1'b0; din_valid = 1'b0;
        tick();
        chk("post_rst_valid", dout_valid, 0);
        shift_cfg = 4'd8;
        beat(256, 1);
        tick();
        chk("post_rst_idle", dout, 1);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            reset     = ($urandom_range(0, 199) == 0);
            ce        = ($urandom_range(0, 3) != 0);
            din_valid = ($urandom_range(0, 2) != 0);
            din_last  = ($urandom_range(0, 3) == 0);
            ovf_clr   = ($urandom_range(0, 31) == 0);
            shift_cfg = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) begin
                s = $urandom_range(0, 15);
                k = longint'($urandom_range(0, 200)) - 100;
                d = k * (longint'(1) << s) + ((s > 0) ? (longint'(1) << (s - 1)) : 0);
                din = DW'(d);
            end else begin
                v   = DW'({$urandom, $urandom});
                din = v >>> $urandom_range(0, 30);
            end
            tick();
        end
        reset = 1'b0; ce = 1'b1; din_valid = 1'b0; ovf_clr = 1'b0;
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
